// File: rtl/lstm_ctrl_pkg.sv
// Shared definitions for the LSTM sequence controller.
// Holds the controller state encoding, default timing/shape parameters and
// small constant helpers used to size index and counter registers.
package lstm_ctrl_pkg;

  localparam int unsigned MacCyclesDef = 2;
  localparam int unsigned ActDelayDef  = 1;
  localparam int unsigned SeqLenDef    = 16;
  localparam int unsigned NumLayersDef = 1;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StMatMul,
    StFunc,
    StWaitAct,
    StHidden,
    StDone
  } lstm_state_e;

  // Index width for a counter spanning 0..n-1; never narrower than 1 bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lstm_phase_counter.sv
// Down-counter timing the MAT_MUL and WAIT_ACT phases.
// Ports:
//   clk      - clock
//   rst      - synchronous active-low reset
//   clr      - synchronous clear (run abort)
//   load     - load load_val on this edge
//   load_val - phase length minus one
//   expire   - high while the count is zero (last cycle of the phase)
module lstm_phase_counter #(
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic             expire
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/lstm_seq_controller.sv
// Sequencer for an LSTM accelerator: per time step it runs a MAC phase, an
// activation/cell-update strobe, an activation settle delay and a hidden-state
// latch, over SEQ_LEN steps and NUM_LAYERS stacked layers.
// Ports:
//   clk, rst      - clock, synchronous active-low reset
//   enable_input  - level run request; low aborts to idle
//   Clear_State   - clear cell/hidden state at layer start (1 cycle)
//   Mac_EN        - high through the MAT_MUL phase
//   Fun_Cell_EN   - activation and cell-update strobe (1 cycle)
//   Hidden_EN     - hidden-state latch strobe (1 cycle)
//   step_idx      - current time step
//   layer_idx     - current layer
//   busy, done    - status
module lstm_seq_controller
  import lstm_ctrl_pkg::*;
#(
  parameter int unsigned MAC_CYCLES = MacCyclesDef,
  parameter int unsigned ACT_DELAY  = ActDelayDef,
  parameter int unsigned SEQ_LEN    = SeqLenDef,
  parameter int unsigned NUM_LAYERS = NumLayersDef
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enable_input,
  output logic                                Clear_State,
  output logic                                Mac_EN,
  output logic                                Fun_Cell_EN,
  output logic                                Hidden_EN,
  output logic [idx_width(SEQ_LEN)-1:0]       step_idx,
  output logic [idx_width(NUM_LAYERS)-1:0]    layer_idx,
  output logic                                busy,
  output logic                                done
);

  localparam int unsigned CntW   = $clog2(max_u(MAC_CYCLES, ACT_DELAY)) + 1;
  localparam int unsigned StepW  = idx_width(SEQ_LEN);
  localparam int unsigned LayerW = idx_width(NUM_LAYERS);

  localparam logic [StepW-1:0]  LastStep  = StepW'(SEQ_LEN - 1);
  localparam logic [LayerW-1:0] LastLayer = LayerW'(NUM_LAYERS - 1);
  localparam logic [CntW-1:0]   MacLoad   = CntW'(MAC_CYCLES - 1);
  localparam logic [CntW-1:0]   ActLoad   = CntW'(ACT_DELAY - 1);

  lstm_state_e     state_q;
  logic            cnt_load;
  logic [CntW-1:0] cnt_val;
  logic            cnt_expire;

  // Reload on the edge that enters MAT_MUL or WAIT_ACT so no count carries over.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = MacLoad;
    unique case (state_q)
      StClear:  cnt_load = 1'b1;
      StHidden: cnt_load = (step_idx != LastStep);
      StFunc: begin
        cnt_load = 1'b1;
        cnt_val  = ActLoad;
      end
      default: ;
    endcase
  end

  lstm_phase_counter #(
    .Width (CntW)
  ) u_phase_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (~enable_input),
    .load     (cnt_load),
    .load_val (cnt_val),
    .expire   (cnt_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst || !enable_input) begin
      state_q   <= StIdle;
      step_idx  <= '0;
      layer_idx <= '0;
    end else begin
      unique case (state_q)
        StIdle:    state_q <= StClear;
        StClear:   state_q <= StMatMul;
        StMatMul:  if (cnt_expire) state_q <= StFunc;
        StFunc:    state_q <= StWaitAct;
        StWaitAct: if (cnt_expire) state_q <= StHidden;
        StHidden: begin
          if (step_idx != LastStep) begin
            step_idx <= step_idx + 1'b1;
            state_q  <= StMatMul;
          end else if (layer_idx != LastLayer) begin
            step_idx  <= '0;
            layer_idx <= layer_idx + 1'b1;
            state_q   <= StClear;
          end else begin
            state_q <= StDone;
          end
        end
        StDone:    state_q <= StDone;
        default:   state_q <= StIdle;
      endcase
    end
  end

  // Strobes gated by enable_input so nothing fires in an abort cycle.
  assign Clear_State = enable_input & (state_q == StClear);
  assign Mac_EN      = enable_input & (state_q == StMatMul);
  assign Fun_Cell_EN = enable_input & (state_q == StFunc);
  assign Hidden_EN   = enable_input & (state_q == StHidden);
  assign busy        = (state_q != StIdle) && (state_q != StDone);
  assign done        = (state_q == StDone);

endmodule

// File: tb/tb_lstm_seq_controller.sv
module tb_lstm_seq_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  // A: defaults with SEQ_LEN=2; B: MAC=4 ACT=3 SEQ=3; C: two layers of two steps
  logic       clr_a, mac_a, fun_a, hid_a, busy_a, done_a;
  logic [0:0] step_a, layer_a;
  logic       clr_b, mac_b, fun_b, hid_b, busy_b, done_b;
  logic [1:0] step_b;
  logic [0:0] layer_b;
  logic       clr_c, mac_c, fun_c, hid_c, busy_c, done_c;
  logic [0:0] step_c, layer_c;

  lstm_seq_controller #(.MAC_CYCLES(2), .ACT_DELAY(1), .SEQ_LEN(2), .NUM_LAYERS(1)) u_a (
    .clk(clk), .rst(rst), .enable_input(en), .Clear_State(clr_a), .Mac_EN(mac_a),
    .Fun_Cell_EN(fun_a), .Hidden_EN(hid_a), .step_idx(step_a), .layer_idx(layer_a),
    .busy(busy_a), .done(done_a));

  lstm_seq_controller #(.MAC_CYCLES(4), .ACT_DELAY(3), .SEQ_LEN(3), .NUM_LAYERS(1)) u_b (
    .clk(clk), .rst(rst), .enable_input(en), .Clear_State(clr_b), .Mac_EN(mac_b),
    .Fun_Cell_EN(fun_b), .Hidden_EN(hid_b), .step_idx(step_b), .layer_idx(layer_b),
    .busy(busy_b), .done(done_b));

  lstm_seq_controller #(.MAC_CYCLES(2), .ACT_DELAY(1), .SEQ_LEN(2), .NUM_LAYERS(2)) u_c (
    .clk(clk), .rst(rst), .enable_input(en), .Clear_State(clr_c), .Mac_EN(mac_c),
    .Fun_Cell_EN(fun_c), .Hidden_EN(hid_c), .step_idx(step_c), .layer_idx(layer_c),
    .busy(busy_c), .done(done_c));

  logic [5:0] out_a, out_b, out_c;
  assign out_a = {clr_a, mac_a, fun_a, hid_a, busy_a, done_a};
  assign out_b = {clr_b, mac_b, fun_b, hid_b, busy_b, done_b};
  assign out_c = {clr_c, mac_c, fun_c, hid_c, busy_c, done_c};

  typedef struct packed {
    logic [5:0]  o;      // {clr, mac, fun, hid, busy, done}
    logic [15:0] step;
    logic [15:0] layer;
  } exp_t;

  // Expected {clr,mac,fun,hid,busy,done} for config A, cycle 1 = first cycle after start edge.
  function automatic logic [5:0] exp_a(input int cyc);
    logic [5:0] e;
    e[5] = (cyc == 1);
    e[4] = (cyc == 2) || (cyc == 3) || (cyc == 7) || (cyc == 8);
    e[3] = (cyc == 4) || (cyc == 9);
    e[2] = (cyc == 6) || (cyc == 11);
    e[1] = (cyc >= 1) && (cyc <= 11);
    e[0] = (cyc >= 12);
    return e;
  endfunction

  // Timeline model: mode 0 idle, 1 running (t cycles since the CLEAR cycle), 2 done.
  function automatic exp_t model_out(input int mac, input int act, input int seq, input int nl,
                                     input int mode, input int t, input logic en_v);
    exp_t e;
    int   p, l, o, r;
    e = '0;
    p = mac + act + 2;
    l = 1 + seq * p;
    if (mode == 1) begin
      e.o[1]  = 1'b1;
      e.layer = 16'(t / l);
      o = t % l;
      if (o == 0) begin
        e.o[5] = en_v;
      end else begin
        e.step = 16'((o - 1) / p);
        r = (o - 1) % p;
        if (r < mac) e.o[4] = en_v;
        else if (r == mac) e.o[3] = en_v;
        else if (r == p - 1) e.o[2] = en_v;
      end
    end else if (mode == 2) begin
      e.o[0]  = 1'b1;
      e.step  = 16'(seq - 1);
      e.layer = 16'(nl - 1);
    end
    return e;
  endfunction

  task automatic model_step(input int total, input logic rst_v, input logic en_v,
                            inout int mode, inout int t);
    if (!rst_v || !en_v) begin
      mode = 0;
      t    = 0;
    end else if (mode == 0) begin
      mode = 1;
      t    = 0;
    end else if (mode == 1) begin
      if (t == total - 1) mode = 2;
      else t = t + 1;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    en  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    en  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (out_a !== 6'b0) begin n_fail++; $display("FAIL reset_out_a: got %b want 000000", out_a); end
    n_tests++;
    if (out_b !== 6'b0) begin n_fail++; $display("FAIL reset_out_b: got %b want 000000", out_b); end
    n_tests++;
    if (out_c !== 6'b0) begin n_fail++; $display("FAIL reset_out_c: got %b want 000000", out_c); end
    n_tests++;
    if ({step_a, layer_a, step_b, layer_b, step_c, layer_c} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_idx: got %b want 0000000",
               {step_a, layer_a, step_b, layer_b, step_c, layer_c});
    end
  endtask

  task automatic test_default_seq();
    apply_reset();
    en = 1'b1;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (out_a !== exp_a(cyc)) begin
        n_fail++;
        $display("FAIL default_seq_out cyc %0d: got %b want %b", cyc, out_a, exp_a(cyc));
      end
      n_tests++;
      if (step_a !== ((cyc >= 7) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL default_seq_step cyc %0d: got %b want %b", cyc, step_a, cyc >= 7);
      end
    end
  endtask

  // Continues from the finished run of test_default_seq.
  task automatic test_done_hold();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (out_a !== 6'b000001) begin
        n_fail++;
        $display("FAIL done_hold %0d: got %b want 000001", i, out_a);
      end
    end
    en = 1'b0;
    #1;
    n_tests++;
    if (out_a !== 6'b000001) begin n_fail++; $display("FAIL done_drop_same: got %b want 000001", out_a); end
    @(posedge clk);
    #1;
    n_tests++;
    if (out_a !== 6'b0) begin n_fail++; $display("FAIL done_to_idle: got %b want 000000", out_a); end
  endtask

  task automatic test_step_period();
    int hcyc[$];
    int hstep[$];
    int dcyc;
    int nmac;
    apply_reset();
    dcyc = 0;
    nmac = 0;
    en = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      #1;
      if (hid_b) begin hcyc.push_back(cyc); hstep.push_back(int'(step_b)); end
      if (mac_b) nmac++;
      if (done_b && dcyc == 0) dcyc = cyc;
    end
    n_tests++;
    if (hcyc.size() != 3) begin
      n_fail++;
      $display("FAIL period_hid_count: got %0d want 3", hcyc.size());
    end else begin
      n_tests++;
      if (hcyc[0] != 10) begin n_fail++; $display("FAIL period_first_hid: got %0d want 10", hcyc[0]); end
      for (int i = 1; i < 3; i++) begin
        n_tests++;
        if (hcyc[i] - hcyc[i-1] != 9) begin
          n_fail++;
          $display("FAIL period_gap %0d: got %0d want 9", i, hcyc[i] - hcyc[i-1]);
        end
      end
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (hstep[i] != i) begin n_fail++; $display("FAIL period_step %0d: got %0d want %0d", i, hstep[i], i); end
      end
    end
    n_tests++;
    if (nmac != 12) begin n_fail++; $display("FAIL period_mac_cycles: got %0d want 12", nmac); end
    n_tests++;
    if (dcyc != 29) begin n_fail++; $display("FAIL period_done: got %0d want 29", dcyc); end
  endtask

  task automatic test_layers();
    int hcyc[$];
    int hlay[$];
    int nclr;
    int dcyc;
    logic [0:0] lay12;
    apply_reset();
    nclr  = 0;
    dcyc  = 0;
    lay12 = 1'b0;
    en = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clk);
      #1;
      if (clr_c) nclr++;
      if (hid_c) begin hcyc.push_back(cyc); hlay.push_back(int'(layer_c)); end
      if (cyc == 12) lay12 = layer_c;
      if (done_c && dcyc == 0) dcyc = cyc;
    end
    n_tests++;
    if (nclr != 2) begin n_fail++; $display("FAIL layers_clear_count: got %0d want 2", nclr); end
    n_tests++;
    if (hcyc.size() != 4) begin
      n_fail++;
      $display("FAIL layers_hid_count: got %0d want 4", hcyc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (hlay[i] != i / 2) begin
          n_fail++;
          $display("FAIL layers_hid_layer %0d: got %0d want %0d", i, hlay[i], i / 2);
        end
      end
      n_tests++;
      if (dcyc != hcyc[3] + 1) begin
        n_fail++;
        $display("FAIL layers_done: got %0d want %0d", dcyc, hcyc[3] + 1);
      end
    end
    n_tests++;
    if (lay12 !== 1'b1) begin n_fail++; $display("FAIL layers_idx_after_2nd: got %b want 1", lay12); end
  endtask

  task automatic test_abort_func();
    apply_reset();
    en = 1'b1;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (out_a !== exp_a(cyc)) begin
        n_fail++;
        $display("FAIL abort_pre cyc %0d: got %b want %b", cyc, out_a, exp_a(cyc));
      end
    end
    en = 1'b0;
    #1;
    n_tests++;
    if (out_a !== 6'b000010) begin n_fail++; $display("FAIL abort_func_strobe: got %b want 000010", out_a); end
    @(posedge clk);
    #1;
    n_tests++;
    if ({out_a, step_a, layer_a} !== 8'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got %b want 00000000", {out_a, step_a, layer_a});
    end
    en = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if ({out_a, step_a} !== {exp_a(cyc), 1'b0}) begin
        n_fail++;
        $display("FAIL abort_restart cyc %0d: got %b want %b", cyc, {out_a, step_a},
                 {exp_a(cyc), 1'b0});
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    en = 1'b1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (out_a !== 6'b000010) begin n_fail++; $display("FAIL rstmid_wait: got %b want 000010", out_a); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    n_tests++;
    if ({out_a, step_a, layer_a} !== 8'b0) begin
      n_fail++;
      $display("FAIL rstmid_cleared: got %b want 00000000", {out_a, step_a, layer_a});
    end
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (out_a !== exp_a(cyc)) begin
        n_fail++;
        $display("FAIL rstmid_restart cyc %0d: got %b want %b", cyc, out_a, exp_a(cyc));
      end
    end
  endtask

  task automatic test_random();
    int   mb, tb_, mc, tc;
    exp_t eb, ec;
    apply_reset();
    mb = 0; tb_ = 0; mc = 0; tc = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 59) != 0);
      en  = ($urandom_range(0, 24) != 0);
      #1;
      eb = model_out(4, 3, 3, 1, mb, tb_, en);
      ec = model_out(2, 1, 2, 2, mc, tc, en);
      n_tests++;
      if ({out_b, step_b, layer_b} !== {eb.o, eb.step[1:0], eb.layer[0:0]}) begin
        n_fail++;
        $display("FAIL random_b %0d: got %b want %b", i, {out_b, step_b, layer_b},
                 {eb.o, eb.step[1:0], eb.layer[0:0]});
      end
      n_tests++;
      if ({out_c, step_c, layer_c} !== {ec.o, ec.step[0:0], ec.layer[0:0]}) begin
        n_fail++;
        $display("FAIL random_c %0d: got %b want %b", i, {out_c, step_c, layer_c},
                 {ec.o, ec.step[0:0], ec.layer[0:0]});
      end
      @(posedge clk);
      model_step(28, rst, en, mb, tb_);
      model_step(22, rst, en, mc, tc);
    end
  endtask

  initial begin
    test_reset();
    test_default_seq();
    test_done_hold();
    test_step_period();
    test_layers();
    test_abort_func();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/lstm_seq_controller.md
LSTM_SEQ_CONTROLLER -- requirements
Module: lstm_seq_controller

Interface
REQ-001 Parameter MAC_CYCLES, 2, MAT_MUL phase length in cycles; legal range 1..256.
REQ-002 Parameter ACT_DELAY, 1, idle cycles between Fun_Cell_EN and Hidden_EN; legal range 1..256.
REQ-003 Parameter SEQ_LEN, 16, time steps per layer; legal range 1..1024.
REQ-004 Parameter NUM_LAYERS, 1, stacked LSTM layers processed back to back; legal range 1..16.
REQ-005 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1, synchronous active-low reset.
REQ-007 Port enable_input, input, 1, level run request; low aborts any operation.
REQ-008 Port Clear_State, output, 1, one-cycle strobe clearing the cell and hidden state at layer start.
REQ-009 Port Mac_EN, output, 1, high throughout the MAT_MUL phase.
REQ-010 Port Fun_Cell_EN, output, 1, one-cycle activation and cell-update strobe.
REQ-011 Port Hidden_EN, output, 1, one-cycle hidden-state latch strobe.
REQ-012 Port step_idx, output, max(1,clog2(SEQ_LEN)), current time step.
REQ-013 Port layer_idx, output, max(1,clog2(NUM_LAYERS)), current layer.
REQ-014 Port busy, output, 1, high in any state other than IDLE or DONE.
REQ-015 Port done, output, 1, high while in DONE.

Function
REQ-016 The FSM SHALL have states IDLE, CLEAR, MAT_MUL, FUNC, WAIT_ACT, HIDDEN and DONE.
REQ-017 IDLE SHALL go to CLEAR on the first edge with enable_input=1, and otherwise stay in IDLE.
REQ-018 CLEAR SHALL last 1 cycle with Clear_State=1, then go to MAT_MUL.
REQ-019 MAT_MUL SHALL last exactly MAC_CYCLES cycles with Mac_EN=1, then go to FUNC.
REQ-020 FUNC SHALL last 1 cycle with Fun_Cell_EN=1, then go to WAIT_ACT.
REQ-021 WAIT_ACT SHALL last exactly ACT_DELAY cycles with all strobes low, then go to HIDDEN.
REQ-022 HIDDEN SHALL last 1 cycle with Hidden_EN=1; transitions on exit:
- step_idx<SEQ_LEN-1: increment step_idx, go to MAT_MUL.
- last step, not last layer: step_idx:=0, increment layer_idx, go to CLEAR.
- last step of last layer: go to DONE.
REQ-023 Step period SHALL be MAC_CYCLES+ACT_DELAY+2 cycles.
REQ-024 DONE SHALL hold done=1 while enable_input=1, and return to IDLE when enable_input=0; a new run needs enable_input low, then high.
REQ-025 enable_input=0 in any state other than IDLE SHALL force IDLE at the next edge and clear step_idx, layer_idx and the phase counter.
REQ-026 Mac_EN, Fun_Cell_EN, Hidden_EN and Clear_State SHALL be the state decode ANDed with enable_input, so no strobe fires in an abort cycle.
REQ-027 The phase counter SHALL be reloaded on each entry to MAT_MUL and WAIT_ACT; no count SHALL carry over between phases.
REQ-028 SEQ_LEN=1 and NUM_LAYERS=1 SHALL be legal: one pass, then DONE.

Reset
REQ-029 rst=0 at a rising edge SHALL force IDLE, step_idx=0, layer_idx=0, phase counter=0, and all outputs 0.
REQ-030 Reset SHALL override enable_input and take effect mid-operation in any state.

Structure
REQ-031 The state encoding and the parameter defaults SHALL live in the shared package lstm_ctrl_pkg.
REQ-032 The MAT_MUL and WAIT_ACT durations SHALL come from one sub-module, lstm_phase_counter:
- inputs: load, load value;
- output: expire;
- width: clog2(max(MAC_CYCLES,ACT_DELAY)) plus 1.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- Defaults with SEQ_LEN=2, enable_input raised before edge 1 -> CLEAR in cycle 1, Mac_EN in cycles 2-3, Fun_Cell_EN in cycle 4, Hidden_EN in cycle 6, Mac_EN in cycles 7-8, Hidden_EN in cycle 11, done=1 from cycle 12.
- MAC_CYCLES=4, ACT_DELAY=3, SEQ_LEN=3 -> Hidden_EN pulses exactly 9 cycles apart; step_idx reads 0, 1, 2.
- NUM_LAYERS=2, SEQ_LEN=2 -> Clear_State pulses twice; layer_idx goes 0 to 1 after the 2nd Hidden_EN; done after the 4th Hidden_EN.
- enable_input dropped in the FUNC cycle -> Fun_Cell_EN=0 that cycle; IDLE and zeroed indices next cycle; re-enable restarts at CLEAR with step_idx=0.
- rst=0 for one edge during WAIT_ACT -> all outputs 0 next cycle; no Hidden_EN is issued.
- enable_input held high in DONE -> done stays 1 and no restart; dropping it -> IDLE next cycle.
